// File: rtl/state_rmw_pkg.sv
// Shared types for the fetch-and-op state read-modify-write block.
// Op field sits directly above the W-bit operand in the command word.
package state_rmw_pkg;

  typedef enum logic [1:0] {
    OpAdd  = 2'd0,
    OpSub  = 2'd1,
    OpSwap = 2'd2,
    OpRead = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StResp  = 2'd2
  } fsm_t;

  localparam int unsigned OperandLsb = 0;
  localparam int unsigned OpWidth    = 2;

  function automatic int unsigned op_lsb(input int unsigned w);
    return w;
  endfunction

endpackage

// File: rtl/state_rmw_alu.sv
// Combinational next-value ALU for state_rmw.
// STATE_RMW_SAT_EN selects unsigned saturating ADD/SUB instead of wrapping.
module state_rmw_alu
  import state_rmw_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  op_t          i_op,
  input  logic [W-1:0] i_old,
  input  logic [W-1:0] i_operand,
  output logic [W-1:0] o_new
);

`ifdef STATE_RMW_SAT_EN
  // Extra MSB carries the carry-out / borrow used to clamp.
  logic [W:0] w_sum;
  logic [W:0] w_diff;
  assign w_sum  = {1'b0, i_old} + {1'b0, i_operand};
  assign w_diff = {1'b0, i_old} - {1'b0, i_operand};
`endif

  always_comb begin
    o_new = i_old;
    unique case (i_op)
      OpAdd: begin
`ifdef STATE_RMW_SAT_EN
        o_new = w_sum[W] ? '1 : w_sum[W-1:0];
`else
        o_new = i_old + i_operand;
`endif
      end
      OpSub: begin
`ifdef STATE_RMW_SAT_EN
        o_new = w_diff[W] ? '0 : w_diff[W-1:0];
`else
        o_new = i_old - i_operand;
`endif
      end
      OpSwap: o_new = i_operand;
      OpRead: o_new = i_old;
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/state_rmw.sv
// Fetch-and-op controller: reads the state holder, writes back the ALU result and
// returns the pre-operation value. Build with STATE_RMW_SAT_EN for saturating ADD/SUB.
module state_rmw
  import state_rmw_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  input  logic [W+1:0] i_cmd_data,
  output logic         o_cmd_ready,
  output logic         o_st_rd_valid,
  output logic [0:0]   o_st_rd_data,
  input  logic         i_st_rd_ready,
  input  logic         i_st_val_valid,
  input  logic [W-1:0] i_st_val_data,
  output logic         o_st_val_ready,
  output logic         o_st_din_valid,
  output logic [W-1:0] o_st_din_data,
  input  logic         i_st_din_ready,
  output logic         o_res_valid,
  output logic [W-1:0] o_res_data,
  input  logic         i_res_ready
);

  localparam int unsigned OpLsb = op_lsb(W);

  fsm_t         r_state;
  logic [W-1:0] r_old;
  logic [W-1:0] r_new;
  op_t          w_op;
  logic [W-1:0] w_operand;
  logic [W-1:0] w_alu_new;
  logic         w_run;
  logic         w_unused;

  assign w_op      = op_t'(i_cmd_data[OpLsb +: OpWidth]);
  assign w_operand = i_cmd_data[OperandLsb +: W];
  // Read acceptance is implied by the st_val handshake.
  assign w_unused  = i_st_rd_ready;

  state_rmw_alu #(
    .W (W)
  ) u_alu (
    .i_op      (w_op),
    .i_old     (i_st_val_data),
    .i_operand (w_operand),
    .o_new     (w_alu_new)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_old   <= '0;
      r_new   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid && i_st_val_valid) begin
            r_old   <= i_st_val_data;
            r_new   <= w_alu_new;
            r_state <= (w_op == OpRead) ? StResp : StWrite;
          end
        end
        StWrite: if (i_st_din_ready) r_state <= StResp;
        StResp:  if (i_res_ready) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Gating on reset keeps a reset-cycle write or response from being handshaken.
  assign w_run          = !i_rst;
  assign o_st_rd_valid  = w_run && (r_state == StIdle) && i_cmd_valid;
  assign o_st_rd_data   = 1'b0;
  assign o_st_val_ready = o_st_rd_valid;
  assign o_st_din_valid = w_run && (r_state == StWrite);
  assign o_st_din_data  = r_new;
  assign o_res_valid    = w_run && (r_state == StResp);
  assign o_res_data     = r_old;
  assign o_cmd_ready    = o_res_valid && i_res_ready;

endmodule

// File: tb/tb_state_rmw.sv
// Directed self-checking bench for state_rmw (W=16) with a behavioural state holder.
module tb_state_rmw;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_SWAP = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [17:0] cmd_data = '0;
  logic        cmd_ready;
  logic        st_rd_valid;
  logic [0:0]  st_rd_data;
  logic        st_rd_ready = 1'b1;
  logic        st_val_valid = 1'b1;
  logic [15:0] st_val_data;
  logic        st_val_ready;
  logic        st_din_valid;
  logic [15:0] st_din_data;
  logic        st_din_ready = 1'b1;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready = 1'b1;

  logic        preload_en = 1'b0;
  logic [15:0] preload_val = '0;
  logic [15:0] hold_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // State holder: accepts writes on the st_din handshake, preloadable by the bench.
  always @(posedge clk) begin
    if (preload_en) hold_q <= preload_val;
    else if (st_din_valid && st_din_ready) hold_q <= st_din_data;
  end
  assign st_val_data = hold_q;

  state_rmw #(.W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (cmd_valid),
    .i_cmd_data     (cmd_data),
    .o_cmd_ready    (cmd_ready),
    .o_st_rd_valid  (st_rd_valid),
    .o_st_rd_data   (st_rd_data),
    .i_st_rd_ready  (st_rd_ready),
    .i_st_val_valid (st_val_valid),
    .i_st_val_data  (st_val_data),
    .o_st_val_ready (st_val_ready),
    .o_st_din_valid (st_din_valid),
    .o_st_din_data  (st_din_data),
    .i_st_din_ready (st_din_ready),
    .o_res_valid    (res_valid),
    .o_res_data     (res_data),
    .i_res_ready    (res_ready)
  );

  // Entry and exit are #1 after a rising edge.
  task automatic set_state(input logic [15:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
  endtask

  // Issues one command and collects response, any write, and cycles taken.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] opnd,
                         output logic [15:0] r, output logic wr, output logic [15:0] wd,
                         output int cyc);
    logic done;
    done = 1'b0; wr = 1'b0; wd = '0; r = '0; cyc = 0;
    cmd_valid = 1'b1;
    cmd_data  = {op, opnd};
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (st_din_valid && st_din_ready) begin wr = 1'b1; wd = st_din_data; end
      if (res_valid && res_ready) begin r = res_data; done = 1'b1; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL cmd_timeout got=%b exp=1", done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (st_din_valid !== 1'b0) begin fails++; $display("FAIL rst_din_valid got=%b exp=0", st_din_valid); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    tests++; if (res_data !== 16'h0000) begin fails++; $display("FAIL rst_old got=%h exp=0000", res_data); end
    tests++; if (st_din_data !== 16'h0000) begin fails++; $display("FAIL rst_new got=%h exp=0000", st_din_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add_read();
    logic [15:0] r, wd; logic wr; int cyc;
    set_state(16'd5);
    run_cmd(OP_ADD, 16'd3, r, wr, wd, cyc);
    tests++; if (r !== 16'd5) begin fails++; $display("FAIL add_res got=%h exp=%h", r, 16'd5); end
    tests++; if (wr !== 1'b1 || wd !== 16'd8) begin fails++; $display("FAIL add_din got=%b/%h exp=1/0008", wr, wd); end
    tests++; if (cyc !== 3) begin fails++; $display("FAIL add_latency got=%0d exp=3", cyc); end
    tests++; if (hold_q !== 16'd8) begin fails++; $display("FAIL add_state got=%h exp=0008", hold_q); end
    run_cmd(OP_READ, 16'd0, r, wr, wd, cyc);
    tests++; if (r !== 16'd8) begin fails++; $display("FAIL read_res got=%h exp=0008", r); end
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL read_nowrite got=%b exp=0", wr); end
    tests++; if (cyc !== 2) begin fails++; $display("FAIL read_latency got=%0d exp=2", cyc); end
  endtask

  task automatic test_sub_underflow();
    logic [15:0] r, wd, exp_wd; logic wr; int cyc;
`ifdef STATE_RMW_SAT_EN
    exp_wd = 16'h0000;
`else
    exp_wd = 16'hFFFD;
`endif
    set_state(16'h0002);
    run_cmd(OP_SUB, 16'd5, r, wr, wd, cyc);
    tests++; if (r !== 16'h0002) begin fails++; $display("FAIL sub_res got=%h exp=0002", r); end
    tests++; if (wr !== 1'b1 || wd !== exp_wd) begin fails++; $display("FAIL sub_din got=%b/%h exp=1/%h", wr, wd, exp_wd); end
  endtask

  task automatic test_add_overflow();
    logic [15:0] r, wd, exp_wd; logic wr; int cyc;
`ifdef STATE_RMW_SAT_EN
    exp_wd = 16'hFFFF;
`else
    exp_wd = 16'h0002;
`endif
    set_state(16'hFFFE);
    run_cmd(OP_ADD, 16'd4, r, wr, wd, cyc);
    tests++; if (r !== 16'hFFFE) begin fails++; $display("FAIL ovf_res got=%h exp=fffe", r); end
    tests++; if (wr !== 1'b1 || wd !== exp_wd) begin fails++; $display("FAIL ovf_din got=%b/%h exp=1/%h", wr, wd, exp_wd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r, wd; logic wr; int cyc;
    set_state(16'd0);
    run_cmd(OP_SWAP, 16'd7, r, wr, wd, cyc);
    tests++; if (r !== 16'd0 || wd !== 16'd7) begin fails++; $display("FAIL b2b_swap got=%h/%h exp=0000/0007", r, wd); end
    run_cmd(OP_ADD, 16'd1, r, wr, wd, cyc);
    tests++; if (r !== 16'd7 || wd !== 16'd8) begin fails++; $display("FAIL b2b_add got=%h/%h exp=0007/0008", r, wd); end
    run_cmd(OP_READ, 16'd0, r, wr, wd, cyc);
    tests++; if (r !== 16'd8 || wr !== 1'b0) begin fails++; $display("FAIL b2b_read got=%h/%b exp=0008/0", r, wr); end
    tests++; if (hold_q !== 16'd8) begin fails++; $display("FAIL b2b_state got=%h exp=0008", hold_q); end
  endtask

  task automatic test_backpressure();
    logic seen;
    seen = 1'b0;
    set_state(16'h0020);
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = {OP_ADD, 16'd1};
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL bp_reach_resp got=%b exp=1", seen); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== 16'h0020 || cmd_ready !== 1'b0 || st_rd_valid !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got=v%b d%h cr%b rd%b exp=v1 d0020 cr0 rd0",
                 k, res_valid, res_data, cmd_ready, st_rd_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tests++; if (hold_q !== 16'h0021) begin fails++; $display("FAIL bp_state got=%h exp=0021", hold_q); end
  endtask

  task automatic test_stall();
    logic [15:0] r, wd; logic wr; int cyc;
    set_state(16'h1234);
    st_val_valid = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = {OP_READ, 16'd0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (st_rd_valid !== 1'b1 || res_valid !== 1'b0 || st_din_valid !== 1'b0) begin
        fails++;
        $display("FAIL stall%0d got=rd%b res%b din%b exp=rd1 res0 din0", k, st_rd_valid, res_valid, st_din_valid);
      end
      @(posedge clk); #1;
    end
    st_val_valid = 1'b1;
    run_cmd(OP_READ, 16'd0, r, wr, wd, cyc);
    tests++; if (r !== 16'h1234) begin fails++; $display("FAIL stall_res got=%h exp=1234", r); end
  endtask

  task automatic test_reset_in_write();
    logic [15:0] r, wd; logic wr; int cyc;
    set_state(16'd3);
    st_din_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = {OP_ADD, 16'd10};
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (st_din_valid !== 1'b1) begin fails++; $display("FAIL rw_in_write got=%b exp=1", st_din_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (st_din_valid !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b0 || st_rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rw_valids got=din%b res%b cr%b rd%b exp=all0", st_din_valid, res_valid, cmd_ready, st_rd_valid);
    end
    tests++; if (hold_q !== 16'd3) begin fails++; $display("FAIL rw_state_kept got=%h exp=0003", hold_q); end
    @(posedge clk); #1;
    rst = 1'b0;
    st_din_ready = 1'b1;
    run_cmd(OP_ADD, 16'd10, r, wr, wd, cyc);
    tests++; if (r !== 16'd3 || wd !== 16'd13) begin fails++; $display("FAIL rw_retry got=%h/%h exp=0003/000d", r, wd); end
    tests++; if (hold_q !== 16'd13) begin fails++; $display("FAIL rw_final got=%h exp=000d", hold_q); end
  endtask

  initial begin
    test_reset();
    test_add_read();
    test_sub_underflow();
    test_add_overflow();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/state_rmw.md
STATE_RMW -- requirements
Module: state_rmw

Interface
REQ-001 Parameter: W, default 16, width of the stored state value and of the command operand.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: cmd  dti.consumer  2+W  command: data[W+1:W] = op, data[W-1:0] = operand.
REQ-005 Port: st_rd  dti.producer  1  read request to the downstream state holder; data is tied 0.
REQ-006 Port: st_val  dti.consumer  W  current value returned by the state holder.
REQ-007 Port: st_din  dti.producer  W  new value written into the state holder.
REQ-008 Port: res  dti.producer  W  pre-operation value returned per command (fetch-and-op).

Function
REQ-009 Op encoding: 0 ADD (old+operand), 1 SUB (old-operand), 2 SWAP (new=operand), 3 READ (no write).
REQ-010 FSM states: IDLE, WRITE, RESP; exactly one command is in flight at a time.
REQ-011 IDLE: st_rd.valid and st_val.ready equal cmd.valid; no other valid is asserted.
REQ-012 IDLE, st_val handshake: old_reg <= st_val.data; new_reg <= ALU result; next state is WRITE, or RESP for op READ.
REQ-013 WRITE: st_din.valid=1, st_din.data=new_reg; on st_din handshake, next state is RESP.
REQ-014 RESP: res.valid=1, res.data=old_reg; cmd.ready = res.ready; on res handshake, next state is IDLE.
REQ-015 cmd.ready is 0 outside RESP; cmd.data must stay stable while cmd.valid=1 and is read in IDLE only.
REQ-016 Latency: ADD/SUB/SWAP occupy 3 cycles minimum (IDLE, WRITE, RESP); READ occupies 2 cycles minimum; each extra stall cycle adds one.
REQ-017 The write is committed at the st_din handshake edge, so the next IDLE read always returns the updated value (no RAW hazard).
REQ-018 Without saturation, ADD/SUB wrap modulo 2^W; the carry/borrow is discarded.
REQ-019 If st_val.valid=0 while in IDLE with cmd.valid=1, the FSM stays in IDLE and holds st_rd.valid high.
REQ-020 Back-pressure on res holds the FSM in RESP with res.data stable.

Reset
REQ-021 On rst=1: state=IDLE, old_reg=0, new_reg=0; st_din.valid=0, res.valid=0, cmd.ready=0 in the following cycle.
REQ-022 Reset in WRITE drops the write; the state holder keeps its prior value and the command is not consumed.
REQ-023 Reset in RESP drops the response and does not consume the command.

Configuration
REQ-024 Macro STATE_RMW_SAT_EN defined: ADD clamps at 2^W-1 and SUB clamps at 0 (unsigned saturation).
REQ-025 Macro STATE_RMW_SAT_EN undefined: ADD/SUB wrap per REQ-018, and the saturation logic is not compiled in.

Structure
REQ-026 Package state_rmw_pkg holds: op_t enum (ADD, SUB, SWAP, READ), fsm_t enum (IDLE, WRITE, RESP), and the op field offsets.
REQ-027 Sub-module state_rmw_alu, purely combinational: inputs op, old and operand; output new value; saturation is guarded by STATE_RMW_SAT_EN.
REQ-028 The top module holds the FSM, old_reg, new_reg and all handshake logic.

Verification
REQ-029 W=16, state holds 5; cmd ADD 3 -> res=5, st_din=8, then cmd READ -> res=8, no st_din.valid.
REQ-030 State 0x0002; cmd SUB 5 -> res=2 and st_din=0xFFFD without the macro, st_din=0x0000 with STATE_RMW_SAT_EN.
REQ-031 State 0xFFFE; cmd ADD 4 -> st_din=0x0002 wrapped, or 0xFFFF with STATE_RMW_SAT_EN.
REQ-032 Back-to-back cmds SWAP 7, ADD 1, READ -> responses 0, 7, 8; final state 8.
REQ-033 res.ready=0 for 4 cycles in RESP -> res.data stable, cmd.ready=0, no new st_rd.valid until the handshake.
REQ-034 rst asserted in WRITE of ADD 10 on state 3 -> state holder remains 3, all valids 0 next cycle, and the re-presented cmd completes with res=3, st_din=13.
